// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and default geometry for the memory-bus arbiter
package bus_pkg;

    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_TAG_WIDTH   = 13;
    localparam int DEF_READ_BEATS  = 8;
    localparam int DEF_WRITE_BEATS = 8;
    localparam int TAG_WRITE_BIT   = DEF_TAG_WIDTH - 1;

    typedef enum logic [2:0] {IDLE, REQ, WDATA, RESP, DONE} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    // Counter only has to reach the larger burst's last index.
    function automatic int beat_cnt_width(input int rd_beats, input int wr_beats);
        int m;
        m = (rd_beats > wr_beats) ? rd_beats : wr_beats;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick; gnt is the winning index (0=m0, 1=m1)
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt
);

    always_comb begin
        gnt = 1'b0;
        if (req0 && req1) begin
            gnt = ~last;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares the memory bus between icache (m0) and dcache (m1),
// holding the grant for a whole request+response or request+write-data transaction
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int READ_BEATS     = DEF_READ_BEATS,
    parameter int WRITE_BEATS    = DEF_WRITE_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int CNT_W  = beat_cnt_width(READ_BEATS, WRITE_BEATS);
    localparam int WR_BIT = BUS_TAG_WIDTH - 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BEATS - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BEATS - 1);

    arb_state_t              state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                      pick;
    logic                      own_m1;
    logic                      own_reqcyc;
    logic                      own_respack;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

    rr_arb2 u_rr (
        .req0 (m0_reqcyc),
        .req1 (m1_reqcyc),
        .last (last_q),
        .gnt  (pick)
    );

    assign own_m1      = (owner_q == OWN_M1);
    assign own_reqcyc  = own_m1 ? m1_reqcyc  : m0_reqcyc;
    assign own_req     = own_m1 ? m1_req     : m0_req;
    assign own_reqtag  = own_m1 ? m1_reqtag  : m0_reqtag;
    assign own_respack = own_m1 ? m1_respack : m0_respack;

    // Response data and tag are broadcast; only respcyc is steered.
    assign m0_resp    = bus_resp;
    assign m1_resp    = bus_resp;
    assign m0_resptag = bus_resptag;
    assign m1_resptag = bus_resptag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (m0_reqcyc || m1_reqcyc) begin
                    owner_d = pick ? OWN_M1 : OWN_M0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (own_reqcyc && bus_reqack) begin
                    cnt_d   = '0;
                    state_d = own_reqtag[WR_BIT] ? WDATA : RESP;
                end
            end
            WDATA: begin
                if (own_reqcyc && bus_reqack) begin
                    if (cnt_q == WR_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus_respcyc && own_respack) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                last_d  = own_m1;
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        m0_reqack   = 1'b0;
        m1_reqack   = 1'b0;
        m0_respcyc  = 1'b0;
        m1_respcyc  = 1'b0;
        case (state_q)
            REQ, WDATA: begin
                bus_reqcyc = own_reqcyc;
                bus_req    = own_req;
                bus_reqtag = own_reqtag;
                m0_reqack  = bus_reqack & ~own_m1;
                m1_reqack  = bus_reqack & own_m1;
            end
            RESP: begin
                m0_respcyc  = bus_respcyc & ~own_m1;
                m1_respcyc  = bus_respcyc & own_m1;
                bus_respack = own_respack;
            end
            default: begin
            end
        endcase
    end

    // A response beat outside a read burst is a bus protocol error.
    resp_outside_read: assert property (@(posedge clk) disable iff (!reset)
        !(bus_respcyc && (state_q inside {IDLE, REQ, WDATA})));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int DW = 64;
    localparam int TW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_reqcyc, m1_reqcyc, m0_respack, m1_respack;
    logic [DW-1:0] m0_req, m1_req;
    logic [TW-1:0] m0_reqtag, m1_reqtag;
    logic          m0_reqack, m1_reqack, m0_respcyc, m1_respcyc;
    logic [DW-1:0] m0_resp, m1_resp;
    logic [TW-1:0] m0_resptag, m1_resptag;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .READ_BEATS     (8),
        .WRITE_BEATS    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_reqcyc   (m0_reqcyc),
        .m0_req      (m0_req),
        .m0_reqtag   (m0_reqtag),
        .m0_reqack   (m0_reqack),
        .m0_respcyc  (m0_respcyc),
        .m0_resp     (m0_resp),
        .m0_resptag  (m0_resptag),
        .m0_respack  (m0_respack),
        .m1_reqcyc   (m1_reqcyc),
        .m1_req      (m1_req),
        .m1_reqtag   (m1_reqtag),
        .m1_reqack   (m1_reqack),
        .m1_respcyc  (m1_respcyc),
        .m1_resp     (m1_resp),
        .m1_resptag  (m1_resptag),
        .m1_respack  (m1_respack),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_reqcyc = 1'b0; m0_req = '0; m0_reqtag = '0; m0_respack = 1'b0;
        m1_reqcyc = 1'b0; m1_req = '0; m1_reqtag = '0; m1_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Supplies eight response beats, one per cycle; caller sets respack.
    task automatic rd_burst();
        for (int i = 0; i < 8; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hB0 + 64'(i);
            tick();
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        tests++;
        if ({bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc} !== 6'b0) begin
            fails++;
            $display("FAIL reset_cyc_ack: got %b want 000000",
                     {bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc});
        end
        tests++;
        if (bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin
            fails++;
            $display("FAIL reset_bus_req: got %h/%h want 0/0", bus_req, bus_reqtag);
        end
        tick();
        tests++;
        if (dut.state_q !== IDLE || dut.last_q !== 1'b1 || dut.cnt_q !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got st=%0d last=%b cnt=%0d want st=0 last=1 cnt=0",
                     dut.state_q, dut.last_q, dut.cnt_q);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        int bad;
        logic [DW-1:0] exp_d;
        do_reset();
        m0_reqcyc = 1'b1; m0_req = 64'h1000; m0_reqtag = 13'h0001;
        #1;
        tests++;
        if (bus_reqcyc !== 1'b0) begin
            fails++;
            $display("FAIL rd_arb_latency: got bus_reqcyc=%b want 0", bus_reqcyc);
        end
        tick();
        tests++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h1000, 13'h0001}) begin
            fails++;
            $display("FAIL rd_req_mirror: got %b %h %h want 1 1000 0001", bus_reqcyc, bus_req, bus_reqtag);
        end
        bus_reqack = 1'b1;
        #1;
        tests++;
        if ({m0_reqack, m1_reqack} !== 2'b10) begin
            fails++;
            $display("FAIL rd_reqack: got m0/m1=%b want 10", {m0_reqack, m1_reqack});
        end
        tick();
        m0_reqcyc = 1'b0; bus_reqack = 1'b0; m0_respack = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            exp_d = 64'hA0 + 64'(i);
            bus_respcyc = 1'b1; bus_resp = exp_d; bus_resptag = 13'h0001;
            #1;
            if (m0_respcyc !== 1'b1 || m1_respcyc !== 1'b0 || m0_resp !== exp_d ||
                m0_resptag !== 13'h0001 || bus_respack !== 1'b1) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rd_beats: got %0d bad beats want 0", bad);
        end
        bus_respcyc = 1'b0;
        #1;
        tests++;
        if (dut.state_q !== DONE || m0_respcyc !== 1'b0) begin
            fails++;
            $display("FAIL rd_done: got st=%0d respcyc=%b want st=4 respcyc=0", dut.state_q, m0_respcyc);
        end
        tick();
        tests++;
        if (dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL rd_idle: got st=%0d want 0", dut.state_q);
        end
    endtask

    task automatic test_round_robin();
        bit [2:0]      order;
        logic          exp_m1;
        logic [DW-1:0] exp_addr;
        order = 3'b010;
        do_reset();
        m0_reqcyc = 1'b1; m0_req = 64'h100; m0_reqtag = 13'h2; m0_respack = 1'b1;
        m1_reqcyc = 1'b1; m1_req = 64'h200; m1_reqtag = 13'h3; m1_respack = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            exp_m1   = order[g];
            exp_addr = exp_m1 ? 64'h200 : 64'h100;
            bus_reqack = 1'b1;
            #1;
            tests++;
            if (bus_req !== exp_addr || {m1_reqack, m0_reqack} !== {exp_m1, ~exp_m1}) begin
                fails++;
                $display("FAIL rr_grant%0d: got addr=%h ack m1/m0=%b%b want addr=%h", g,
                         bus_req, m1_reqack, m0_reqack, exp_addr);
            end
            tick();
            bus_reqack = 1'b0;
            rd_burst();
            tests++;
            if (bus_reqcyc !== 1'b0 || dut.state_q !== DONE) begin
                fails++;
                $display("FAIL rr_done%0d: got st=%0d reqcyc=%b want st=4 reqcyc=0", g, dut.state_q, bus_reqcyc);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_write();
        int k, cyc, bad;
        bit stall3, stall5;
        logic [DW-1:0] exp_d;
        do_reset();
        m1_reqcyc = 1'b1; m1_req = 64'h3000; m1_reqtag = 13'h1005;
        tick();
        bus_reqack = 1'b1;
        #1;
        tests++;
        if (bus_reqtag !== 13'h1005 || m1_reqack !== 1'b1 || m0_reqack !== 1'b0) begin
            fails++;
            $display("FAIL wr_req: got tag=%h m1ack=%b m0ack=%b want 1005 1 0", bus_reqtag, m1_reqack, m0_reqack);
        end
        tick();
        k = 0; cyc = 0; bad = 0; stall3 = 1'b0; stall5 = 1'b0;
        while (k < 8 && cyc < 20) begin
            exp_d  = 64'hD0 + 64'(k);
            m1_req = exp_d;
            if (k == 3 && !stall3) begin
                bus_reqack = 1'b0; stall3 = 1'b1;
            end else if (k == 5 && !stall5) begin
                bus_reqack = 1'b0; stall5 = 1'b1;
            end else begin
                bus_reqack = 1'b1;
            end
            #1;
            if (bus_reqcyc !== 1'b1 || bus_req !== exp_d || m1_reqack !== bus_reqack ||
                m0_respcyc !== 1'b0 || m1_respcyc !== 1'b0) bad++;
            tick();
            cyc++;
            if (bus_reqack) k++;
        end
        tests++;
        if (bad != 0 || cyc != 10) begin
            fails++;
            $display("FAIL wr_beats: got bad=%0d cycles=%0d want 0 10", bad, cyc);
        end
        m1_reqcyc = 1'b0; bus_reqack = 1'b0;
        #1;
        tests++;
        if (dut.state_q !== DONE || bus_reqcyc !== 1'b0) begin
            fails++;
            $display("FAIL wr_done: got st=%0d reqcyc=%b want st=4 reqcyc=0", dut.state_q, bus_reqcyc);
        end
        tick();
        tests++;
        if (dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL wr_idle: got st=%0d want 0", dut.state_q);
        end
    endtask

    task automatic test_backpressure_isolation();
        int acked, cyc, bad, hold_bad;
        do_reset();
        m0_reqcyc = 1'b1; m0_req = 64'h4000; m0_reqtag = 13'h4;
        tick();
        m1_reqcyc = 1'b1; m1_req = 64'h5000; m1_reqtag = 13'h5; m1_respack = 1'b1;
        bus_reqack = 1'b1;
        #1;
        tests++;
        if (m1_reqack !== 1'b0 || bus_req !== 64'h4000) begin
            fails++;
            $display("FAIL iso_req: got m1ack=%b addr=%h want 0 4000", m1_reqack, bus_req);
        end
        tick();
        m0_reqcyc = 1'b0; bus_reqack = 1'b0;
        acked = 0; cyc = 0; bad = 0; hold_bad = 0;
        while (acked < 8 && cyc < 20) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hC0 + 64'(acked);
            m0_respack  = !(cyc >= 4 && cyc <= 6);
            #1;
            if (m1_respcyc !== 1'b0 || m1_reqack !== 1'b0 || m0_respcyc !== 1'b1 ||
                bus_respack !== m0_respack) bad++;
            if (!m0_respack && dut.cnt_q !== 3'd4) hold_bad++;
            tick();
            cyc++;
            if (m0_respack) acked++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_iso_routing: got %0d bad cycles want 0", bad);
        end
        tests++;
        if (hold_bad != 0 || cyc != 11) begin
            fails++;
            $display("FAIL bp_hold: got hold_bad=%0d cycles=%0d want 0 11", hold_bad, cyc);
        end
        bus_respcyc = 1'b0;
        #1;
        tests++;
        if (dut.state_q !== DONE) begin
            fails++;
            $display("FAIL bp_done: got st=%0d want 4", dut.state_q);
        end
        tick();
        tick();
        tests++;
        if (bus_reqcyc !== 1'b1 || bus_req !== 64'h5000) begin
            fails++;
            $display("FAIL iso_late_grant: got reqcyc=%b addr=%h want 1 5000", bus_reqcyc, bus_req);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m0_reqcyc = 1'b1; m0_req = 64'h6000; m0_reqtag = 13'h6; m0_respack = 1'b1;
        tick();
        bus_reqack = 1'b1;
        tick();
        m0_reqcyc = 1'b0; bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_respcyc = 1'b1; bus_resp = 64'hE0 + 64'(i);
            tick();
        end
        bus_respcyc = 1'b1; bus_resp = 64'hE4;
        #1;
        tests++;
        if (m0_respcyc !== 1'b1) begin
            fails++;
            $display("FAIL ar_pre: got m0_respcyc=%b want 1", m0_respcyc);
        end
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if ({bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc} !== 6'b0 ||
            dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL ar_outputs: got %b st=%0d want 000000 st=0",
                     {bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc}, dut.state_q);
        end
        clear_inputs();
        #1;
        reset = 1'b1;
        m1_reqcyc = 1'b1; m1_req = 64'h7000; m1_reqtag = 13'h7; m1_respack = 1'b1;
        tick();
        bus_reqack = 1'b1;
        #1;
        tests++;
        if (bus_req !== 64'h7000 || m1_reqack !== 1'b1 || m0_reqack !== 1'b0) begin
            fails++;
            $display("FAIL ar_m1_grant: got addr=%h m1ack=%b m0ack=%b want 7000 1 0", bus_req, m1_reqack, m0_reqack);
        end
        tick();
        bus_reqack = 1'b0;
        m0_reqcyc = 1'b1; m0_req = 64'h8000; m0_reqtag = 13'h8;
        rd_burst();
        tick();
        tick();
        tests++;
        if (dut.state_q !== REQ || bus_req !== 64'h8000) begin
            fails++;
            $display("FAIL ar_tie_m0: got st=%0d addr=%h want st=1 addr=8000", dut.state_q, bus_req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_backpressure_isolation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
